// File: rtl/mandelbrot_pkg.sv
// Shared constants for the Mandelbrot pipeline: sequencer state encoding and
// the default datapath widths used by the scanner, iterator and colour stage.
package mandelbrot_pkg;

    localparam int DEF_WIDTH  = 11;
    localparam int DEF_ITER_W = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/mandelbrot_alu.sv
// One combinational Mandelbrot step on signed fixed point with WIDTH-3 fraction bits:
// z' = z^2 + c (saturated), size = |z|^2 > 4 evaluated on the incoming z.
module mandelbrot_alu #(
    parameter int WIDTH = 11
) (
    input  logic signed [WIDTH-1:0] in_cr,
    input  logic signed [WIDTH-1:0] in_ci,
    input  logic signed [WIDTH-1:0] in_zr,
    input  logic signed [WIDTH-1:0] in_zi,
    output logic signed [WIDTH-1:0] out_zr,
    output logic signed [WIDTH-1:0] out_zi,
    output logic                    size
);

    localparam int FRAC = WIDTH - 3;
    localparam int PW   = 2 * WIDTH;
    localparam int SW   = 2 * WIDTH + 2;

    localparam logic signed [SW-1:0] ESC_LIMIT = SW'(1) << (2 * FRAC + 2);
    localparam logic signed [SW-1:0] SAT_HI    = SW'((1 << (WIDTH - 1)) - 1);
    localparam logic signed [SW-1:0] SAT_LO    = -SAT_HI - SW'(1);

    logic signed [PW-1:0] w_zr_sq;
    logic signed [PW-1:0] w_zi_sq;
    logic signed [PW-1:0] w_zrzi;
    logic signed [SW-1:0] w_mag;
    logic signed [SW-1:0] w_re;
    logic signed [SW-1:0] w_im;

    assign w_zr_sq = in_zr * in_zr;
    assign w_zi_sq = in_zi * in_zi;
    assign w_zrzi  = in_zr * in_zi;

    assign w_mag = SW'(w_zr_sq) + SW'(w_zi_sq);
    // 2*zr*zi rescaled: one fewer fraction shift absorbs the factor of two
    assign w_re  = ((SW'(w_zr_sq) - SW'(w_zi_sq)) >>> FRAC) + SW'(in_cr);
    assign w_im  = (SW'(w_zrzi) >>> (FRAC - 1)) + SW'(in_ci);

    assign size = (w_mag > ESC_LIMIT);

    always_comb begin
        out_zr = w_re[WIDTH-1:0];
        out_zi = w_im[WIDTH-1:0];
        if (w_re > SAT_HI) out_zr = SAT_HI[WIDTH-1:0];
        if (w_re < SAT_LO) out_zr = SAT_LO[WIDTH-1:0];
        if (w_im > SAT_HI) out_zi = SAT_HI[WIDTH-1:0];
        if (w_im < SAT_LO) out_zi = SAT_LO[WIDTH-1:0];
    end

endmodule

// File: rtl/mandelbrot_iterator.sv
// Per-pixel iteration sequencer: accepts c, iterates z through one ALU per cycle
// until escape or budget exhaustion, then holds the count until it is consumed.
module mandelbrot_iterator
    import mandelbrot_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int ITER_W = DEF_ITER_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_cr,
    input  logic [WIDTH-1:0]  in_ci,
    input  logic [ITER_W-1:0] max_iter,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ITER_W-1:0] out_count,
    output logic              out_escaped,
    output logic [1:0]        dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
    // in_ready/out_valid decode registered state only; out_count/out_escaped are stable
    // for as long as out_valid is high.

    logic [1:0]              r_state;
    logic signed [WIDTH-1:0] r_cr;
    logic signed [WIDTH-1:0] r_ci;
    logic signed [WIDTH-1:0] r_zr;
    logic signed [WIDTH-1:0] r_zi;
    logic [ITER_W-1:0]       r_iter;
    logic [ITER_W-1:0]       r_max;
    logic [ITER_W-1:0]       r_count;
    logic                    r_escaped;

    logic signed [WIDTH-1:0] w_zr_next;
    logic signed [WIDTH-1:0] w_zi_next;
    logic                    w_size;
    logic [ITER_W-1:0]       w_iter_inc;

    mandelbrot_alu #(
        .WIDTH (WIDTH)
    ) alu (
        .in_cr  (r_cr),
        .in_ci  (r_ci),
        .in_zr  (r_zr),
        .in_zi  (r_zi),
        .out_zr (w_zr_next),
        .out_zi (w_zi_next),
        .size   (w_size)
    );

    assign w_iter_inc = r_iter + ITER_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cr      <= '0;
            r_ci      <= '0;
            r_zr      <= '0;
            r_zi      <= '0;
            r_iter    <= '0;
            r_max     <= '0;
            r_count   <= '0;
            r_escaped <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_cr   <= in_cr;
                        r_ci   <= in_ci;
                        r_max  <= max_iter;
                        r_zr   <= '0;
                        r_zi   <= '0;
                        r_iter <= '0;
                        if (max_iter == '0) begin
                            r_count   <= '0;
                            r_escaped <= 1'b0;
                            r_state   <= ST_DONE;
                        end else begin
                            r_state   <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    // Escape wins even when this would also be the last budgeted step
                    if (w_size) begin
                        r_count   <= r_iter;
                        r_escaped <= 1'b1;
                        r_state   <= ST_DONE;
                    end else begin
                        r_zr   <= w_zr_next;
                        r_zi   <= w_zi_next;
                        r_iter <= w_iter_inc;
                        if (w_iter_inc == r_max) begin
                            r_count   <= r_max;
                            r_escaped <= 1'b0;
                            r_state   <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready    = (r_state == ST_IDLE);
    assign out_valid   = (r_state == ST_DONE);
    assign out_count   = r_count;
    assign out_escaped = r_escaped;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_mandelbrot_iterator.sv
// Directed plus randomized bench for mandelbrot_iterator against an integer
// reference model of the escape-time iteration.
module tb_mandelbrot_iterator;

    localparam int WIDTH  = 11;
    localparam int ITER_W = 8;
    localparam int FRAC   = WIDTH - 3;
    localparam int MAXV   = (1 << (WIDTH - 1)) - 1;
    localparam int MINV   = -(1 << (WIDTH - 1));

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [WIDTH-1:0]  in_cr = '0;
    logic [WIDTH-1:0]  in_ci = '0;
    logic [ITER_W-1:0] max_iter = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [ITER_W-1:0] out_count;
    logic              out_escaped;
    logic [1:0]        dbg_state;

    int checks = 0;
    int failures = 0;

    mandelbrot_iterator #(.WIDTH(WIDTH), .ITER_W(ITER_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_cr       (in_cr),
        .in_ci       (in_ci),
        .max_iter    (max_iter),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_count   (out_count),
        .out_escaped (out_escaped),
        .dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int clamp(input int v);
        if (v > MAXV) return MAXV;
        if (v < MINV) return MINV;
        return v;
    endfunction

    // Escape-time reference: z starts at 0; escape is tested on the current z
    // before each budgeted step, so an escape at step it reports count = it.
    function automatic void model(input int cr, input int ci, input int mi,
                                  output int cnt, output int esc);
        int zr, zi, nr, ni;
        zr = 0; zi = 0; cnt = mi; esc = 0;
        for (int it = 0; it < mi; it++) begin
            if (zr * zr + zi * zi > 4 * (1 << (2 * FRAC))) begin
                cnt = it; esc = 1;
                return;
            end
            nr = clamp(((zr * zr - zi * zi) >>> FRAC) + cr);
            ni = clamp(((2 * zr * zi) >>> FRAC) + ci);
            zr = nr; zi = ni;
        end
    endfunction

    function automatic int to_signed(input int raw);
        return (raw > MAXV) ? raw - (1 << WIDTH) : raw;
    endfunction

    // Wait (bounded) for out_valid; lat counts edges after the accept edge.
    task automatic wait_result(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 400) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic check_result(input string tag, input int cr, input int ci,
                                input int mi, input int lat);
        int exp_cnt, exp_esc, exp_lat;
        model(cr, ci, mi, exp_cnt, exp_esc);
        exp_lat = exp_esc ? exp_cnt + 1 : mi;
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_count"}, out_count, exp_cnt);
        check({tag, "_escaped"}, out_escaped, exp_esc);
    endtask

    task automatic run_point(input string tag, input int cr, input int ci, input int mi);
        int lat;
        @(negedge clk);
        check({tag, "_in_ready"}, in_ready, 1);
        in_valid = 1'b1;
        in_cr = WIDTH'(cr);
        in_ci = WIDTH'(ci);
        max_iter = ITER_W'(mi);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_cr = WIDTH'($urandom);
        in_ci = WIDTH'($urandom);
        max_iter = ITER_W'($urandom);
        wait_result(lat);
        check_result(tag, cr, ci, mi, lat);
        @(posedge clk); #1;
        check({tag, "_released"}, out_valid, 0);
    endtask

    initial begin
        int lat, a_cnt, a_esc, seen;
        int rcr, rci, rmi;

        #12;
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_count", out_count, 0);
        check("reset_escaped", out_escaped, 0);
        check("reset_state", dbg_state, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_point("origin_budget", 0, 0, 20);
        run_point("max_pos_escape", 1023, 0, 50);
        run_point("zero_budget", 700, -300, 0);
        run_point("escape_last_iter", 256, 0, 4);
        run_point("exhaust_before_escape", 256, 0, 3);
        run_point("one_iter_budget", 0, 0, 1);

        // Backpressure: result held while out_ready is low and a new request waits.
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_cr = 11'h3FF; in_ci = '0; max_iter = 8'd50;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_result(lat);
        check_result("bp_first", 1023, 0, 50, lat);
        model(1023, 0, 50, a_cnt, a_esc);
        in_valid = 1'b1; in_cr = 11'd256; in_ci = '0; max_iter = 8'd10;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_in_ready", in_ready, 0);
            check("bp_hold_count", out_count, a_cnt);
            check("bp_hold_escaped", out_escaped, a_esc);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_handshake_valid", out_valid, 0);
        check("bp_handshake_in_ready", in_ready, 1);
        @(posedge clk); #1;
        check("bp_next_accepted", in_ready, 0);
        in_valid = 1'b0;
        wait_result(lat);
        check_result("bp_second", 256, 0, 10, lat);
        @(posedge clk); #1;

        // Reset in the middle of a run at iter = 5.
        @(negedge clk);
        in_valid = 1'b1; in_cr = '0; in_ci = '0; max_iter = 8'd20;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrun_rst_in_ready", in_ready, 1);
        check("midrun_rst_out_valid", out_valid, 0);
        check("midrun_rst_count", out_count, 0);
        check("midrun_rst_state", dbg_state, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen = 1;
        end
        check("no_stale_result", seen, 0);
        run_point("after_reset", 256, 0, 4);

        for (int n = 0; n < 25; n++) begin
            rcr = to_signed(int'($urandom_range(0, (1 << WIDTH) - 1)));
            rci = to_signed(int'($urandom_range(0, (1 << WIDTH) - 1)));
            rmi = int'($urandom_range(0, 40));
            run_point("random", rcr, rci, rmi);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
